// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle of ID/EX hazard inputs and the stall/flush/mul-div controls
// produced by hazard_ctrl.
//   slave  modport: used by hazard_ctrl (reads ID/EX fields, drives controls).
//   master modport: used by the pipeline or a testbench (drives ID/EX fields, reads controls).
// Signals:
//   id_rs, id_rt        register fields of the instruction in ID
//   id_use_rs/rt        ID instruction actually reads rs / rt
//   id_md_op            ID instruction is a mul/div
//   ex_wn, ex_WB        destination and WB control (bit 1 = RegWrite) of the EX instruction
//   ex_mem_read         EX instruction is a load
//   branch_taken        branch in EX resolved taken this cycle
//   pc_we, ifid_we      PC / IF-ID write enables
//   ifid_flush          clear IF/ID to a NOP
//   idex_bubble         zero the ID/EX control bits
//   md_start, md_abort  one-cycle pulses to the mul/div unit
//   md_busy             mul/div in progress
//   stall_cnt           saturating count of cycles with pc_we low
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_md_op;
    logic [4:0]       ex_wn;
    logic [1:0]       ex_WB;
    logic             ex_mem_read;
    logic             branch_taken;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             md_start;
    logic             md_abort;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_md_op,
        output ex_wn, ex_WB, ex_mem_read, branch_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble,
        input  md_start, md_abort, md_busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_op,
        input  ex_wn, ex_WB, ex_mem_read, branch_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble,
        output md_start, md_abort, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall controller for the 5-stage MIPS pipeline (ID/EX).
//   - inserts a single bubble for every load-use hazard
//   - sequences the multi-cycle mul/div unit (start, hold IF/ID, release)
//   - applies taken-branch flushes, aborting an in-flight mul/div
//   - keeps a saturating count of cycles with pc_we low
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  hazard_ctrl_if.slave (ID/EX fields in, pipeline controls out)
// Parameters:
//   MD_LAT  mul/div latency from md_start to result valid (2..255)
//   CNT_W   width of stall_cnt
module hazard_ctrl #(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StMdBusy = 2'd1,
        StMdRel  = 2'd2
    } state_e;

    // md_cnt is loaded on the start cycle, so the busy phase covers the remaining MD_LAT-1 cycles.
    localparam logic [7:0] MdInit = 8'(MD_LAT - 1);

    state_e           state_q, state_d;
    logic [7:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic load_use;
    logic rs_hit;
    logic rt_hit;
    logic unused_wb0;

    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic md_start;
    logic md_abort;
    logic md_busy;

    assign unused_wb0 = bus.ex_WB[0];

    // Register 0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign rs_hit   = bus.id_use_rs && (bus.id_rs == bus.ex_wn);
    assign rt_hit   = bus.id_use_rt && (bus.id_rt == bus.ex_wn);
    assign load_use = bus.ex_mem_read && bus.ex_WB[1] && (bus.ex_wn != 5'd0)
                      && (rs_hit || rt_hit);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            md_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next-state logic. Priority: branch_taken, then load_use, then mul/div sequencing.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            StRun: begin
                if (bus.branch_taken) begin
                    state_d = StRun;
                end else if (load_use) begin
                    // A pending mul/div is deferred until the load has moved to MEM.
                    state_d = StRun;
                end else if (bus.id_md_op) begin
                    state_d  = StMdBusy;
                    md_cnt_d = MdInit;
                end
            end
            StMdBusy: begin
                if (bus.branch_taken) begin
                    // An older branch in EX kills the mul/div sitting in ID.
                    state_d  = StRun;
                    md_cnt_d = 8'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 8'd1;
                    if (md_cnt_q == 8'd1) begin
                        state_d = StMdRel;
                    end
                end
            end
            StMdRel: begin
                state_d = StRun;
            end
            default: begin
                state_d  = StRun;
                md_cnt_d = 8'd0;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_start    = 1'b0;
        md_abort    = 1'b0;
        md_busy     = 1'b0;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (bus.id_md_op) begin
                        md_start    = 1'b1;
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                StMdBusy: begin
                    md_busy = 1'b1;
                    if (bus.branch_taken) begin
                        md_abort    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                StMdRel: begin
                    // Defaults let the mul/div advance to EX; md_start stays low even though
                    // id_md_op is still asserted. EX holds a bubble, so load_use cannot fire.
                    if (bus.branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                default: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    // Saturating stall counter; reset cycles are never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (!pc_we && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.md_start    = md_start;
    assign bus.md_abort    = md_abort;
    assign bus.md_busy     = md_busy;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl. Inputs change 1 ns after a rising edge,
// combinational outputs are checked 1 ns later, registered state after the next edge.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    hazard_ctrl_if #(.CNT_W(16)) b ();
    hazard_ctrl_if #(.CNT_W(4))  b4 ();

    hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b.id_rs = 5'd0;        b.id_rt = 5'd0;
        b.id_use_rs = 1'b0;    b.id_use_rt = 1'b0;
        b.id_md_op = 1'b0;     b.ex_wn = 5'd0;
        b.ex_WB = 2'b00;       b.ex_mem_read = 1'b0;
        b.branch_taken = 1'b0;
    endtask

    task automatic load_ex(input logic [4:0] wn, input logic [1:0] wb);
        b.ex_mem_read = 1'b1;
        b.ex_WB       = wb;
        b.ex_wn       = wn;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        b4.id_rs = 5'd0;       b4.id_rt = 5'd0;
        b4.id_use_rs = 1'b0;   b4.id_use_rt = 1'b0;
        b4.id_md_op = 1'b0;    b4.ex_wn = 5'd0;
        b4.ex_WB = 2'b00;      b4.ex_mem_read = 1'b0;
        b4.branch_taken = 1'b0;
        tick();
        tick();

        // Reset behaviour
        check("rst_pc_we", int'(b.pc_we), 0);
        check("rst_ifid_we", int'(b.ifid_we), 0);
        check("rst_bubble", int'(b.idex_bubble), 1);
        check("rst_md_start", int'(b.md_start), 0);
        rst = 1'b0;
        #1;
        check("post_rst_cnt", int'(b.stall_cnt), 0);
        check("post_rst_pc_we", int'(b.pc_we), 1);

        // Reset in the middle of a mul/div
        b.id_md_op = 1'b1;
        #1;
        check("pre_rst_md_start", int'(b.md_start), 1);
        tick();
        check("pre_rst_md_busy", int'(b.md_busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_pc_we", int'(b.pc_we), 0);
        check("midrst_bubble", int'(b.idex_bubble), 1);
        check("midrst_md_busy", int'(b.md_busy), 0);
        check("midrst_md_abort", int'(b.md_abort), 0);
        tick();
        tick();
        rst = 1'b0;
        b.id_md_op = 1'b0;
        #1;
        check("rel_md_busy", int'(b.md_busy), 0);
        check("rel_md_abort", int'(b.md_abort), 0);
        check("rel_pc_we", int'(b.pc_we), 1);
        check("rel_cnt", int'(b.stall_cnt), 0);
        tick();

        // Load-use on rs
        load_ex(5'd5, 2'b10);
        b.id_rs = 5'd5; b.id_use_rs = 1'b1;
        #1;
        check("lu_pc_we", int'(b.pc_we), 0);
        check("lu_ifid_we", int'(b.ifid_we), 0);
        check("lu_bubble", int'(b.idex_bubble), 1);
        tick();
        check("lu_cnt", int'(b.stall_cnt), 1);
        b.ex_mem_read = 1'b0;
        #1;
        check("lu_done_pc_we", int'(b.pc_we), 1);
        tick();
        // ex_wn = 0 never stalls
        load_ex(5'd0, 2'b10);
        b.id_rs = 5'd0; b.id_use_rs = 1'b1;
        #1;
        check("lu_r0_pc_we", int'(b.pc_we), 1);
        tick();
        // rs not used
        load_ex(5'd5, 2'b10);
        b.id_rs = 5'd5; b.id_use_rs = 1'b0;
        #1;
        check("lu_nouse_pc_we", int'(b.pc_we), 1);
        tick();
        // hit through rt
        b.id_rt = 5'd5; b.id_use_rt = 1'b1;
        #1;
        check("lu_rt_pc_we", int'(b.pc_we), 0);
        tick();
        // load without RegWrite
        load_ex(5'd5, 2'b01);
        #1;
        check("lu_nowb_pc_we", int'(b.pc_we), 1);
        tick();
        check("lu_cnt2", int'(b.stall_cnt), 2);
        idle();

        // Mul/div sequencing, MD_LAT = 4
        b.id_md_op = 1'b1;
        #1;
        check("md_T_start", int'(b.md_start), 1);
        check("md_T_pc_we", int'(b.pc_we), 0);
        check("md_T_busy", int'(b.md_busy), 0);
        tick();
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("md_T%0d_busy", i), int'(b.md_busy), 1);
            check($sformatf("md_T%0d_pc_we", i), int'(b.pc_we), 0);
            check($sformatf("md_T%0d_start", i), int'(b.md_start), 0);
            tick();
        end
        check("md_rel_pc_we", int'(b.pc_we), 1);
        check("md_rel_ifid_we", int'(b.ifid_we), 1);
        check("md_rel_start", int'(b.md_start), 0);
        check("md_rel_busy", int'(b.md_busy), 0);
        tick();
        b.id_md_op = 1'b0;
        #1;
        check("md_run_busy", int'(b.md_busy), 0);
        check("md_run_pc_we", int'(b.pc_we), 1);
        check("md_cnt", int'(b.stall_cnt), 6);

        // Branch aborts an in-flight mul/div
        b.id_md_op = 1'b1;
        #1;
        check("ab_start", int'(b.md_start), 1);
        tick();
        b.branch_taken = 1'b1;
        #1;
        check("ab_abort", int'(b.md_abort), 1);
        check("ab_flush", int'(b.ifid_flush), 1);
        check("ab_bubble", int'(b.idex_bubble), 1);
        check("ab_pc_we", int'(b.pc_we), 1);
        tick();
        idle();
        #1;
        check("ab_run_busy", int'(b.md_busy), 0);
        check("ab_run_abort", int'(b.md_abort), 0);
        check("ab_cnt", int'(b.stall_cnt), 7);

        // load_use beats id_md_op
        load_ex(5'd9, 2'b10);
        b.id_rs = 5'd9; b.id_use_rs = 1'b1; b.id_md_op = 1'b1;
        #1;
        check("pr_lu_pc_we", int'(b.pc_we), 0);
        check("pr_lu_start", int'(b.md_start), 0);
        tick();
        b.ex_mem_read = 1'b0;
        #1;
        check("pr_md_start", int'(b.md_start), 1);
        tick();
        for (int i = 0; i < 4; i++) tick();
        idle();
        #1;
        check("pr_cnt", int'(b.stall_cnt), 12);
        // branch_taken beats load_use
        load_ex(5'd9, 2'b10);
        b.id_rs = 5'd9; b.id_use_rs = 1'b1;
        b.branch_taken = 1'b1;
        #1;
        check("pr_br_flush", int'(b.ifid_flush), 1);
        check("pr_br_pc_we", int'(b.pc_we), 1);
        check("pr_br_bubble", int'(b.idex_bubble), 1);
        tick();
        idle();
        #1;
        check("pr_br_cnt", int'(b.stall_cnt), 12);

        // Saturation with a 4-bit counter: continuous load-use stall
        b4.ex_mem_read = 1'b1; b4.ex_WB = 2'b10; b4.ex_wn = 5'd3;
        b4.id_rs = 5'd3; b4.id_use_rs = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check("sat_cnt14", int'(b4.stall_cnt), 14);
        for (int i = 0; i < 6; i++) tick();
        check("sat_cnt20", int'(b4.stall_cnt), 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
